// File: rtl/tape_sdram_arbiter_if.sv
// Bundle of the two requester ports, the SDRAM port and status for tape_sdram_arbiter.
// slave is the arbiter's view; master is the view of the requesters and SDRAM together.
interface tape_sdram_arbiter_if #(
  parameter int AW = 25,
  parameter int DW = 8
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic [DW-1:0] b_rdata;

  logic          sd_req;
  logic          sd_we;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_wdata;
  logic [DW-1:0] sd_rdata;
  logic          sd_ack;

  logic [1:0]    grant;
  logic          busy;
  logic          err;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata,
    output sd_req, sd_we, sd_addr, sd_wdata,
    input  sd_rdata, sd_ack,
    output grant, busy, err
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  sd_req, sd_we, sd_addr, sd_wdata,
    output sd_rdata, sd_ack,
    input  grant, busy, err
  );
endinterface

// File: rtl/tape_sdram_arbiter.sv
// Round-robin arbiter sharing the cassette-image SDRAM port between the tape download
// writer (A) and the playback reader (B), one access at a time, with a hung-access watchdog.
module tape_sdram_arbiter #(
  parameter int AW      = 25,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input logic                clk,
  input logic                reset,
  tape_sdram_arbiter_if.slave bus
);

  localparam logic [11:0] LAST_WAIT = 12'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic          owner_b;
  logic          last_b;
  logic [1:0]    mask;
  logic [11:0]   count;

  logic          a_ack_q;
  logic          b_ack_q;
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;
  logic          sd_req_q;
  logic          sd_we_q;
  logic [AW-1:0] sd_addr_q;
  logic [DW-1:0] sd_wdata_q;
  logic [1:0]    grant_q;
  logic          busy_q;
  logic          err_q;

  logic [1:0]    eligible;
  logic          pick_b;

  // On a tie the port that did not win last time goes next.
  assign eligible = {bus.b_req, bus.a_req} & ~mask;
  assign pick_b   = (eligible == 2'b10) || ((eligible == 2'b11) && !last_b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_b    <= 1'b0;
      last_b     <= 1'b1;
      mask       <= 2'b00;
      count      <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      sd_req_q   <= 1'b0;
      sd_we_q    <= 1'b0;
      sd_addr_q  <= '0;
      sd_wdata_q <= '0;
      grant_q    <= 2'b00;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sd_req_q <= 1'b0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      case (state)
        IDLE: begin
          mask <= 2'b00;
          if (|eligible) begin
            owner_b    <= pick_b;
            grant_q    <= pick_b ? 2'b10 : 2'b01;
            sd_we_q    <= pick_b ? bus.b_we    : bus.a_we;
            sd_addr_q  <= pick_b ? bus.b_addr  : bus.a_addr;
            sd_wdata_q <= pick_b ? bus.b_wdata : bus.a_wdata;
            sd_req_q   <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          count <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A late sd_ack in the final watchdog cycle still counts as success.
          if (bus.sd_ack) begin
            if (!sd_we_q) begin
              if (owner_b) b_rdata_q <= bus.sd_rdata;
              else         a_rdata_q <= bus.sd_rdata;
            end
            a_ack_q <= !owner_b;
            b_ack_q <= owner_b;
            state   <= DONE;
          end else if (count == LAST_WAIT) begin
            err_q <= 1'b1;
            if (!sd_we_q) begin
              if (owner_b) b_rdata_q <= '1;
              else         a_rdata_q <= '1;
            end
            a_ack_q <= !owner_b;
            b_ack_q <= owner_b;
            state   <= DONE;
          end else begin
            count <= count + 12'd1;
          end
        end
        DONE: begin
          last_b  <= owner_b;
          mask    <= owner_b ? 2'b10 : 2'b01;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_ack    = a_ack_q;
  assign bus.b_ack    = b_ack_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.sd_req   = sd_req_q;
  assign bus.sd_we    = sd_we_q;
  assign bus.sd_addr  = sd_addr_q;
  assign bus.sd_wdata = sd_wdata_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_tape_sdram_arbiter.sv
// Randomized bench for tape_sdram_arbiter: requesters plus a behavioural SDRAM responder,
// checked against a transaction-level round-robin/timeout model.
module tb_tape_sdram_arbiter;

  localparam int AW      = 25;
  localparam int DW      = 8;
  localparam int TIMEOUT = 8;

  logic clk;
  logic reset;

  tape_sdram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  tape_sdram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state: transaction-level view of the arbiter.
  bit            last_b;
  bit            err_exp;
  logic [DW-1:0] exp_rdata [2];

  logic          f_we    [2];
  logic [AW-1:0] f_addr  [2];
  logic [DW-1:0] f_wdata [2];

  bit            fix_en [2];
  logic          fix_we;
  logic [AW-1:0] fix_addr;
  logic [DW-1:0] fix_wdata;
  int            fix_delay = -1;
  int            fix_rdata = -1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic new_fields(input int p);
    if (fix_en[p]) begin
      f_we[p]    = fix_we;
      f_addr[p]  = fix_addr;
      f_wdata[p] = fix_wdata;
      fix_en[p]  = 1'b0;
    end else begin
      f_we[p]    = 1'($urandom_range(0, 1));
      f_addr[p]  = AW'($urandom);
      f_wdata[p] = DW'($urandom);
    end
    if (p == 0) begin
      bus.a_we = f_we[0]; bus.a_addr = f_addr[0]; bus.a_wdata = f_wdata[0];
    end else begin
      bus.b_we = f_we[1]; bus.b_addr = f_addr[1]; bus.b_wdata = f_wdata[1];
    end
  endtask

  // 0 = SDRAM never answers; TIMEOUT+1 = answers one cycle too late.
  function automatic int pick_delay();
    int d;
    if (fix_delay >= 0) begin
      d = fix_delay;
      fix_delay = -1;
    end else if ($urandom_range(0, 5) == 0) begin
      d = ($urandom_range(0, 1) != 0) ? 0 : TIMEOUT + 1;
    end else begin
      d = int'($urandom_range(1, TIMEOUT));
    end
    return d;
  endfunction

  task automatic applyStimulus(input bit use_a, input bit use_b, input int n_each);
    int            left [2];
    bit            pend [2];
    int            owner, issue_cyc, exp_ack_cyc, ack_at, req_cyc, budget, d;
    bit            inflight, first, exp_to;
    logic [DW-1:0] drv;
    left[0] = use_a ? n_each : 0;
    left[1] = use_b ? n_each : 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = (left[p] > 0);
      if (pend[p]) new_fields(p);
    end
    bus.a_req = pend[0];
    bus.b_req = pend[1];
    req_cyc = cyc; first = 1'b1; inflight = 1'b0; ack_at = -1;
    owner = 0; issue_cyc = 0; exp_ack_cyc = 0; exp_to = 1'b0; drv = '0;
    budget = 200;
    while ((left[0] + left[1]) > 0 && budget > 0) begin
      step();
      budget--;
      bus.sd_ack = (cyc == ack_at);
      if (bus.sd_ack) begin
        bus.sd_rdata = (fix_rdata >= 0) ? DW'(fix_rdata) : DW'($urandom);
        fix_rdata = -1;
        drv = bus.sd_rdata;
      end
      if (bus.a_ack || bus.b_ack) begin
        if (!inflight) begin
          checkOutput("unexpected_ack", {bus.b_ack, bus.a_ack}, 2'b00);
        end else begin
          checkOutput("ack_port", {bus.b_ack, bus.a_ack}, owner ? 2'b10 : 2'b01);
          checkOutput("ack_latency", cyc - issue_cyc, exp_ack_cyc - issue_cyc);
          if (!f_we[owner]) exp_rdata[owner] = exp_to ? '1 : drv;
          if (exp_to) err_exp = 1'b1;
          checkOutput("a_rdata", bus.a_rdata, exp_rdata[0]);
          checkOutput("b_rdata", bus.b_rdata, exp_rdata[1]);
          checkOutput("err", bus.err, err_exp);
          last_b = (owner == 1);
          left[owner]--;
          inflight = 1'b0;
          if (left[owner] > 0) new_fields(owner);
          else begin
            pend[owner] = 1'b0;
            if (owner == 0) bus.a_req = 1'b0; else bus.b_req = 1'b0;
          end
        end
      end
      if (bus.sd_req) begin
        if (inflight) checkOutput("double_issue", 1, 0);
        if (pend[0] && pend[1]) owner = last_b ? 0 : 1;
        else                    owner = pend[1] ? 1 : 0;
        checkOutput("grant", bus.grant, owner ? 2'b10 : 2'b01);
        checkOutput("busy", bus.busy, 1);
        checkOutput("sd_we", bus.sd_we, f_we[owner]);
        checkOutput("sd_addr", bus.sd_addr, f_addr[owner]);
        checkOutput("sd_wdata", bus.sd_wdata, f_wdata[owner]);
        if (first) checkOutput("req_to_sdreq", cyc - req_cyc, 1);
        first = 1'b0;
        d = pick_delay();
        exp_to = (d == 0) || (d > TIMEOUT);
        issue_cyc = cyc;
        ack_at = (d > 0) ? cyc + d : -1;
        exp_ack_cyc = cyc + (exp_to ? TIMEOUT + 1 : d + 1);
        inflight = 1'b1;
      end
    end
    if (budget == 0) checkOutput("cycle_budget", left[0] + left[1], 0);
    bus.sd_ack = 1'b0;
    step();
    step();
    checkOutput("idle_busy", bus.busy, 0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.sd_ack = 0; bus.sd_rdata = '0;
    last_b = 1'b1; err_exp = 1'b0; exp_rdata[0] = '0; exp_rdata[1] = '0;
    fix_en[0] = 0; fix_en[1] = 0; fix_we = 0; fix_addr = '0; fix_wdata = '0;
    step();
    step();
    checkOutput("rst_outputs", {bus.sd_req, bus.a_ack, bus.b_ack, bus.grant, bus.busy, bus.err}, 0);
    checkOutput("rst_rdata", {bus.a_rdata, bus.b_rdata}, 0);
    checkOutput("rst_sd_addr", bus.sd_addr, 0);
    reset = 1'b0;
    step();

    $display("[TB] both ports held from reset");
    applyStimulus(1, 1, 3);

    $display("[TB] single A read at 0x10");
    fix_en[0] = 1; fix_we = 0; fix_addr = 25'h0000010; fix_wdata = 8'h00;
    fix_delay = 3; fix_rdata = 8'h55;
    applyStimulus(1, 0, 1);
    checkOutput("t1_a_rdata", bus.a_rdata, 8'h55);

    $display("[TB] B read at top address, fastest SDRAM");
    fix_en[1] = 1; fix_we = 0; fix_addr = 25'h1FFFFFF;
    fix_delay = 1; fix_rdata = 8'h3C;
    applyStimulus(0, 1, 1);
    checkOutput("t3_b_rdata", bus.b_rdata, 8'h3C);

    $display("[TB] watchdog timeout then normal access");
    fix_en[0] = 1; fix_we = 0; fix_addr = 25'h0000123; fix_delay = 0;
    applyStimulus(1, 0, 1);
    checkOutput("t4_a_rdata", bus.a_rdata, 8'hFF);
    fix_delay = TIMEOUT;
    applyStimulus(1, 0, 1);
    checkOutput("t4_err_sticky", bus.err, 1);

    $display("[TB] A write and spurious sd_ack");
    fix_en[0] = 1; fix_we = 1; fix_addr = 25'h0000200; fix_wdata = 8'hA5;
    applyStimulus(1, 0, 1);
    bus.sd_ack = 1'b1;
    bus.sd_rdata = 8'h99;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.sd_ack = 1'b0;
      if (bus.a_ack || bus.b_ack || bus.busy) seen = 1;
    end
    checkOutput("spur_activity", seen, 0);
    checkOutput("spur_a_rdata", bus.a_rdata, exp_rdata[0]);
    checkOutput("spur_b_rdata", bus.b_rdata, exp_rdata[1]);

    $display("[TB] randomized traffic");
    for (int g = 0; g < 40; g++) begin
      int sel;
      sel = int'($urandom_range(1, 3));
      applyStimulus(sel[0], sel[1], int'($urandom_range(1, 3)));
    end

    $display("[TB] reset during WAIT");
    if (!err_exp) begin
      fix_delay = 0;
      applyStimulus(1, 0, 1);
    end
    bus.a_we = 0; bus.a_addr = 25'h0000042; bus.a_req = 1; bus.b_req = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus.sd_req) seen = 1;
    end
    checkOutput("rst_issue_seen", seen, 1);
    step();
    reset = 1'b1;
    #1;
    checkOutput("midrst_outputs", {bus.sd_req, bus.a_ack, bus.b_ack, bus.grant, bus.busy, bus.err}, 0);
    checkOutput("midrst_rdata", {bus.a_rdata, bus.b_rdata}, 0);
    bus.a_req = 0;
    step();
    reset = 1'b0;
    last_b = 1'b1; err_exp = 1'b0; exp_rdata[0] = '0; exp_rdata[1] = '0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.a_ack || bus.b_ack || bus.sd_req) seen = 1;
    end
    checkOutput("post_rst_quiet", seen, 0);
    applyStimulus(1, 1, 1);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
